cmap_encoder: RTL and testbench

CMAP_ENCODER -- requirements
Module: cmap_encoder

---
 rtl/cmap_pkg.sv | 23 ++
 rtl/cmap_encoder_if.sv | 34 +++
 rtl/cmap_group_compact.sv | 35 +++
 rtl/cmap_encoder.sv | 160 ++++++++++++++++
 tb/tb_cmap_encoder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmap_pkg.sv
// Shared definitions for the compressed-map encoder/decoder pair:
// FSM states and width helpers derived from the tiling parameters.
package cmap_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } cmap_state_e;

   // A group count must hold ZNZ_BITS itself, hence the extra bit.
   function automatic int cnt_width(input int znz_bits);
      return $clog2(znz_bits) + 1;
   endfunction

   function automatic int beat_width(input int din_bytes, input int data_w);
      return din_bytes * data_w;
   endfunction

   function automatic int buf_cnt_width(input int din_bytes);
      return $clog2(2 * din_bytes) + 1;
   endfunction

endpackage

// File: rtl/cmap_encoder_if.sv
// Raw input, bitmap, count and packed-data channels of the encoder.
interface cmap_encoder_if #(
   parameter int DATA_W    = 8,
   parameter int ZNZ_BITS  = 16,
   parameter int NUM_GROUP = 4,
   parameter int DIN_BYTES = ZNZ_BITS * NUM_GROUP
);
   localparam int CNT_W = cmap_pkg::cnt_width(ZNZ_BITS);

   logic [DIN_BYTES*DATA_W-1:0]  raw_din;
   logic                         raw_vld;
   logic                         raw_rdy;
   logic                         raw_last;
   logic [NUM_GROUP*ZNZ_BITS-1:0] znz_dout;
   logic                         znz_vld;
   logic                         znz_rdy;
   logic [NUM_GROUP*CNT_W-1:0]   nz_num;
   logic                         nz_vld;
   logic                         nz_rdy;
   logic [DIN_BYTES*DATA_W-1:0]  enc_dout;
   logic                         enc_vld;
   logic                         enc_rdy;
   logic                         enc_last;

   modport master (
      output raw_din, raw_vld, raw_last, znz_rdy, nz_rdy, enc_rdy,
      input  raw_rdy, znz_dout, znz_vld, nz_num, nz_vld, enc_dout, enc_vld, enc_last
   );

   modport slave (
      input  raw_din, raw_vld, raw_last, znz_rdy, nz_rdy, enc_rdy,
      output raw_rdy, znz_dout, znz_vld, nz_num, nz_vld, enc_dout, enc_vld, enc_last
   );
endinterface

// File: rtl/cmap_group_compact.sv
// One byte group: nonzero bitmap, popcount, and nonzero bytes packed
// toward byte 0 in ascending index order (upper bytes zero).
module cmap_group_compact
   import cmap_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ZNZ_BITS = 16,
   parameter int CNT_W    = cnt_width(ZNZ_BITS)
)(
   input  logic [ZNZ_BITS*DATA_W-1:0] din,
   output logic [ZNZ_BITS-1:0]        bitmap,
   output logic [CNT_W-1:0]           nz_cnt,
   output logic [ZNZ_BITS*DATA_W-1:0] packed_bytes
);

   int pos_s;

   // Scan bytes in order, dropping each nonzero one into the next free slot.
   always_comb begin
      bitmap       = '0;
      packed_bytes = '0;
      pos_s        = 0;
      for (int k = 0; k < ZNZ_BITS; k++) begin
         if (din[k*DATA_W +: DATA_W] != '0) begin
            bitmap[k]                           = 1'b1;
            packed_bytes[pos_s*DATA_W +: DATA_W] = din[k*DATA_W +: DATA_W];
            pos_s                               = pos_s + 1;
         end else begin
            bitmap[k] = 1'b0;
         end
      end
      nz_cnt = pos_s[CNT_W-1:0];
   end

endmodule

// File: rtl/cmap_encoder.sv
// Dense-to-sparse encoder: per-beat nonzero bitmap and group counts, plus a
// packing buffer that re-beats the nonzero bytes and flushes on tensor end.
module cmap_encoder
   import cmap_pkg::*;
#(
   parameter int CFG_M     = 8,
   parameter int CFG_N     = 8,
   parameter int DATA_W    = 8,
   parameter int ZNZ_BITS  = 16,
   parameter int NUM_GROUP = 4,
   parameter int DIN_BYTES = ZNZ_BITS * NUM_GROUP
)(
   input logic           clk,
   input logic           rst_n,
   cmap_encoder_if.slave bus
);

   localparam int CNT_W  = cnt_width(ZNZ_BITS);
   localparam int BEAT_W = beat_width(DIN_BYTES, DATA_W);
   localparam int BUF_W  = 2 * BEAT_W;
   localparam int BCNT_W = buf_cnt_width(DIN_BYTES);
   localparam int GRP_W  = ZNZ_BITS * DATA_W;
   localparam logic [BCNT_W-1:0] BEAT_CNT = BCNT_W'(DIN_BYTES);

   if (CFG_M * CFG_N <= 0) begin : g_bad_tile
      $error("cmap_encoder: tile dimensions must be positive");
   end

   logic [NUM_GROUP*ZNZ_BITS-1:0] znz_s;
   logic [NUM_GROUP*CNT_W-1:0]    nz_s;
   logic [BEAT_W-1:0]             grp_bytes_s;
   logic [BEAT_W-1:0]             beat_bytes_s;
   logic [BEAT_W-1:0]             grp_ext_s;
   logic [BCNT_W-1:0]             beat_nz_s;

   cmap_state_e        state_r, state_n;
   logic [BUF_W-1:0]   buf_r, buf_n, base_buf_s;
   logic [BCNT_W-1:0]  buf_cnt_r, cnt_n, base_cnt_s;
   logic               enc_vld_r, enc_last_r;
   logic               znz_vld_r, nz_vld_r, rdy_en_r;
   logic [NUM_GROUP*ZNZ_BITS-1:0] znz_r;
   logic [NUM_GROUP*CNT_W-1:0]    nz_r;
   logic               raw_rdy_s, raw_acc_s, enc_acc_s;

   for (genvar g = 0; g < NUM_GROUP; g++) begin : g_grp
      cmap_group_compact #(
         .DATA_W   (DATA_W),
         .ZNZ_BITS (ZNZ_BITS),
         .CNT_W    (CNT_W)
      ) u_grp (
         .din          (bus.raw_din[g*GRP_W +: GRP_W]),
         .bitmap       (znz_s[g*ZNZ_BITS +: ZNZ_BITS]),
         .nz_cnt       (nz_s[g*CNT_W +: CNT_W]),
         .packed_bytes (grp_bytes_s[g*GRP_W +: GRP_W])
      );
   end

   // Concatenate the compacted groups back to back into one dense run.
   always_comb begin
      beat_bytes_s = '0;
      beat_nz_s    = '0;
      grp_ext_s    = '0;
      for (int g = 0; g < NUM_GROUP; g++) begin
         grp_ext_s              = '0;
         grp_ext_s[GRP_W-1:0]   = grp_bytes_s[g*GRP_W +: GRP_W];
         beat_bytes_s           = beat_bytes_s | (grp_ext_s << (beat_nz_s * DATA_W));
         beat_nz_s              = beat_nz_s + BCNT_W'(nz_s[g*CNT_W +: CNT_W]);
      end
   end

   assign raw_rdy_s = rdy_en_r && (state_r == ST_RUN) && (buf_cnt_r < BEAT_CNT)
                    && (!znz_vld_r || bus.znz_rdy) && (!nz_vld_r || bus.nz_rdy);
   assign raw_acc_s = bus.raw_vld && raw_rdy_s;
   assign enc_acc_s = enc_vld_r && bus.enc_rdy;

   // Next state: retire an emitted beat first, then append the new beat on top.
   always_comb begin
      state_n    = state_r;
      base_buf_s = buf_r;
      base_cnt_s = buf_cnt_r;
      if (enc_acc_s) begin
         base_buf_s = buf_r >> BEAT_W;
         base_cnt_s = (buf_cnt_r > BEAT_CNT) ? (buf_cnt_r - BEAT_CNT) : '0;
         if (enc_last_r) begin
            state_n = ST_RUN;
         end else begin
            state_n = state_r;
         end
      end else begin
         base_buf_s = buf_r;
      end
      buf_n = base_buf_s;
      cnt_n = base_cnt_s;
      if (raw_acc_s) begin
         buf_n = base_buf_s | ({{BEAT_W{1'b0}}, beat_bytes_s} << (base_cnt_s * DATA_W));
         cnt_n = base_cnt_s + beat_nz_s;
         if (bus.raw_last) begin
            state_n = ST_FLUSH;
         end else begin
            state_n = ST_RUN;
         end
      end else begin
         cnt_n = base_cnt_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_n;
      end
   end

   // Packing buffer with its enc handshake flags derived from the next contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_r      <= '0;
         buf_cnt_r  <= '0;
         enc_vld_r  <= 1'b0;
         enc_last_r <= 1'b0;
         rdy_en_r   <= 1'b0;
      end else begin
         buf_r      <= buf_n;
         buf_cnt_r  <= cnt_n;
         enc_vld_r  <= (state_n == ST_FLUSH) || (cnt_n >= BEAT_CNT);
         enc_last_r <= (state_n == ST_FLUSH) && (cnt_n <= BEAT_CNT);
         rdy_en_r   <= 1'b1;
      end
   end

   // One-entry output registers for the bitmap and count channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         znz_r     <= '0;
         znz_vld_r <= 1'b0;
         nz_r      <= '0;
         nz_vld_r  <= 1'b0;
      end else if (raw_acc_s) begin
         znz_r     <= znz_s;
         znz_vld_r <= 1'b1;
         nz_r      <= nz_s;
         nz_vld_r  <= 1'b1;
      end else begin
         znz_vld_r <= znz_vld_r && !bus.znz_rdy;
         nz_vld_r  <= nz_vld_r && !bus.nz_rdy;
      end
   end

   assign bus.raw_rdy  = raw_rdy_s;
   assign bus.znz_dout = znz_r;
   assign bus.znz_vld  = znz_vld_r;
   assign bus.nz_num   = nz_r;
   assign bus.nz_vld   = nz_vld_r;
   assign bus.enc_dout = buf_r[BEAT_W-1:0];
   assign bus.enc_vld  = enc_vld_r;
   assign bus.enc_last = enc_last_r;

endmodule

// File: tb/tb_cmap_encoder.sv
// Scoreboard bench for cmap_encoder: a byte-queue reference model predicts
// bitmap, counts and packed beats; negedge monitors pop and compare.
module tb_cmap_encoder;

   localparam int DATA_W    = 8;
   localparam int ZNZ_BITS  = 16;
   localparam int NUM_GROUP = 4;
   localparam int DIN_BYTES = 64;
   localparam int CNT_W     = 5;

   typedef struct {
      logic [511:0] d;
      logic         l;
   } enc_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   cmap_encoder_if #(.DATA_W(DATA_W), .ZNZ_BITS(ZNZ_BITS), .NUM_GROUP(NUM_GROUP),
                     .DIN_BYTES(DIN_BYTES)) bus ();

   cmap_encoder #(.CFG_M(8), .CFG_N(8), .DATA_W(DATA_W), .ZNZ_BITS(ZNZ_BITS),
                  .NUM_GROUP(NUM_GROUP), .DIN_BYTES(DIN_BYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [63:0] znz_q[$];
   logic [19:0] nz_q[$];
   enc_t        enc_q[$];
   logic [7:0]  mbytes[$];
   int n_checks  = 0;
   int n_fail    = 0;
   int acc_total = 0;
   int bp_mode   = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic pop_beat(input logic last);
      enc_t e;
      e.d = '0;
      e.l = last;
      for (int i = 0; i < 64 && mbytes.size() > 0; i++) e.d[i*8 +: 8] = mbytes.pop_front();
      enc_q.push_back(e);
   endtask

   // Reference: bitmap/counts straight from bytes; nonzero bytes queue up and
   // leave in 64-byte beats, the tail of a tensor as one zero-padded last beat.
   task automatic model_accept(input logic [511:0] din, input logic last);
      logic [63:0] bm;
      logic [19:0] c;
      logic [7:0]  b;
      bm = '0;
      c  = '0;
      for (int k = 0; k < 64; k++) begin
         b = din[k*8 +: 8];
         if (b != 8'd0) begin
            bm[k] = 1'b1;
            c[(k/16)*CNT_W +: CNT_W] = c[(k/16)*CNT_W +: CNT_W] + 5'd1;
            mbytes.push_back(b);
         end
      end
      znz_q.push_back(bm);
      nz_q.push_back(c);
      if (!last) begin
         while (mbytes.size() >= 64) pop_beat(1'b0);
      end else begin
         while (mbytes.size() > 64) pop_beat(1'b0);
         pop_beat(1'b1);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.raw_vld && bus.raw_rdy) begin
         acc_total++;
         model_accept(bus.raw_din, bus.raw_last);
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus.znz_vld && bus.znz_rdy) begin
         check("znz_expected", znz_q.size() != 0, 1);
         if (znz_q.size() != 0) check("znz_dout", bus.znz_dout, znz_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus.nz_vld && bus.nz_rdy) begin
         check("nz_expected", nz_q.size() != 0, 1);
         if (nz_q.size() != 0) check("nz_num", bus.nz_num, nz_q.pop_front());
      end
   end

   always @(negedge clk) begin
      enc_t e;
      if (rst_n && bus.enc_vld && bus.enc_rdy) begin
         check("enc_expected", enc_q.size() != 0, 1);
         if (enc_q.size() != 0) begin
            e = enc_q.pop_front();
            check("enc_dout", bus.enc_dout, e.d);
            check("enc_last", bus.enc_last, e.l);
         end
      end
   end

   // Ready driver: 0 = always ready, 1 = random back-pressure, 2 = enc stalled.
   initial begin
      bus.znz_rdy = 1'b1;
      bus.nz_rdy  = 1'b1;
      bus.enc_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            1: begin
               bus.znz_rdy = ($urandom_range(0, 99) < 70);
               bus.nz_rdy  = ($urandom_range(0, 99) < 70);
               bus.enc_rdy = ($urandom_range(0, 99) < 70);
            end
            2: begin
               bus.znz_rdy = 1'b1;
               bus.nz_rdy  = 1'b1;
               bus.enc_rdy = 1'b0;
            end
            default: begin
               bus.znz_rdy = 1'b1;
               bus.nz_rdy  = 1'b1;
               bus.enc_rdy = 1'b1;
            end
         endcase
      end
   end

   function automatic logic [511:0] make_beat(input int pct);
      logic [511:0] d;
      d = '0;
      for (int k = 0; k < 64; k++)
         if ($urandom_range(0, 99) < pct) d[k*8 +: 8] = 8'($urandom_range(1, 255));
      return d;
   endfunction

   function automatic logic [511:0] make_beat_n(input int n);
      logic [511:0] d;
      int need;
      d = '0;
      need = n;
      for (int k = 0; k < 64; k++) begin
         if ($urandom_range(0, 63 - k) < need) begin
            d[k*8 +: 8] = 8'($urandom_range(1, 255));
            need--;
         end
      end
      return d;
   endfunction

   task automatic send_beat(input logic [511:0] d, input logic last);
      int t;
      t = 0;
      bus.raw_din  = d;
      bus.raw_last = last;
      bus.raw_vld  = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.raw_rdy) break;
         t++;
         if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL raw_accept: not accepted after %0d cycles, required acceptance", t);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.raw_vld  = 1'b0;
      bus.raw_last = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while ((enc_q.size() != 0 || znz_q.size() != 0 || nz_q.size() != 0) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check({tag, "_pending"}, enc_q.size() + znz_q.size() + nz_q.size(), 0);
      check({tag, "_enc_idle"}, bus.enc_vld, 0);
   endtask

   initial begin
      int pcts[5];
      int nb;
      int snap;
      pcts[0] = 0; pcts[1] = 10; pcts[2] = 50; pcts[3] = 90; pcts[4] = 100;
      bus.raw_din  = '0;
      bus.raw_vld  = 1'b0;
      bus.raw_last = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_raw_rdy",  bus.raw_rdy, 0);
      check("rst_znz_vld",  bus.znz_vld, 0);
      check("rst_nz_vld",   bus.nz_vld, 0);
      check("rst_enc_vld",  bus.enc_vld, 0);
      check("rst_enc_last", bus.enc_last, 0);
      check("rst_enc_dout", bus.enc_dout, 0);
      check("rst_znz_dout", bus.znz_dout, 0);
      check("rst_nz_num",   bus.nz_num, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      send_beat({64{8'h01}}, 1'b1);
      drain("all_ones");
      send_beat('0, 1'b1);
      drain("all_zero");
      for (int b = 0; b < 3; b++) send_beat(make_beat_n(40), b == 2);
      drain("three_by_40");

      bp_mode = 2;
      fork
         begin
            send_beat(make_beat_n(64), 1'b0);
            send_beat(make_beat_n(64), 1'b1);
         end
         begin
            snap = acc_total;
            repeat (20) @(posedge clk);
            #3;
            check("stall_accepts", acc_total - snap, 1);
            check("stall_raw_rdy", bus.raw_rdy, 0);
            bp_mode = 0;
         end
      join
      drain("stall");

      send_beat(make_beat_n(30), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_enc_vld", bus.enc_vld, 0);
      check("midrst_znz_vld", bus.znz_vld, 0);
      check("midrst_nz_vld",  bus.nz_vld, 0);
      check("midrst_raw_rdy", bus.raw_rdy, 0);
      znz_q.delete();
      nz_q.delete();
      enc_q.delete();
      mbytes.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("postrst_enc_vld", bus.enc_vld, 0);
      send_beat(make_beat_n(50), 1'b0);
      send_beat(make_beat_n(20), 1'b1);
      drain("after_reset");

      bp_mode = 1;
      for (int t = 0; t < 12; t++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) send_beat(make_beat(pcts[$urandom_range(0, 4)]), b == nb - 1);
      end
      drain("random");
      bp_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
